midi_parser: RTL
================

# midi_parser

Byte-level MIDI 1.0 channel-message parser between the UART receiver (`rx_done`/`dout`) and the synth voice/control logic. It assembles status and data bytes into complete events, honours running status, and ignores real-time and SysEx traffic. It filters by channel and presents one event at a time on a valid/ready output.

## Interface
- `OMNI`, default 1: 1 = accept all channels; 0 = accept only `CHANNEL`.
- `CHANNEL`, default 0: 4-bit channel number used when `OMNI`=0.
- `clk` in 1: system clock.
- `reset` in 1: **asynchronous, active-high** reset.
- `byte_valid` in 1: one-cycle strobe, received byte available (driven by UART `rx_done`).
- `byte_in` in 8: received byte (driven by UART `dout`); sampled only when `byte_valid`=1.
- `ev_valid` out 1: event pending.
- `ev_ready` in 1: consumer accepts the event.
- `ev_type` out 2: `EV_NOTE_OFF`=0, `EV_NOTE_ON`=1, `EV_CC`=2, `EV_BEND`=3.
- `ev_chan` out 4: channel of the event.
- `ev_d1` out 7: note, CC number, or bend LSB.
- `ev_d2` out 7: velocity, CC value, or bend MSB.
- `ev_overflow` out 1: one-cycle pulse when a completed event is dropped.

## Operation
- Byte classes:
  - real-time: 0xF8–0xFF.
  - system common: 0xF0–0xF7.
  - channel status: 0x80–0xEF.
  - data: bit7=0.
- Real-time bytes are ignored in every state. They do not change state, running status or data registers.
- FSM states:
  - IDLE: no running status. Data bytes are discarded.
  - WAIT_D1: running status valid, expecting the first data byte.
  - WAIT_D2: expecting the second data byte, with `d1_reg` held.
  - SYSEX: discarding bytes.
- Transitions on `byte_valid`:
  - Channel status, any state: latch `status_reg`, go to WAIT_D1. Any partial message is discarded.
  - 0xF0, any state: clear running status, go to SYSEX.
  - 0xF1–0xF7, any state: clear running status, go to IDLE. 0xF7 in SYSEX ends it.
  - SYSEX + data byte: stay in SYSEX.
  - WAIT_D1 + data byte:
    - Status nibble 0xC or 0xD (one-data-byte message): message complete, discarded, stay in WAIT_D1.
    - Otherwise: latch `d1_reg`, go to WAIT_D2.
  - WAIT_D2 + data byte: message complete, return to WAIT_D1 (running status kept).
- Completed messages and their events:
  - 0x8n → `EV_NOTE_OFF`.
  - 0x9n with d2≠0 → `EV_NOTE_ON`.
  - 0x9n with d2=0 → `EV_NOTE_OFF` with d2=0.
  - 0xBn → `EV_CC`.
  - 0xEn → `EV_BEND`.
  - 0xAn, 0xCn, 0xDn → parsed for length, no event.
- Channel filter: if `OMNI`=0 and n≠`CHANNEL`, the message is parsed normally and no event is produced.
- Output register, single entry:
  - Loaded on the completing byte when the message produces an event and the register is free. The register is free when `ev_valid`=0, or when `ev_valid`&`ev_ready` in the same cycle.
  - If the register is occupied, the new event is dropped and `ev_overflow` pulses. The held event is unchanged.
- `ev_*` fields are stable while `ev_valid`=1.

## Timing
- Reset, asynchronous, immediate:
  - State = IDLE; `status_reg`=0; `d1_reg`=0.
  - `ev_valid`=0, `ev_type`=0, `ev_chan`=0, `ev_d1`=0, `ev_d2`=0, `ev_overflow`=0.
  - Reset asserted mid-message discards the partial message. A pending event is lost.
- Latency: `ev_valid` rises on the first clock edge after the completing `byte_valid` cycle.
- Handshake: the transfer occurs on a cycle with `ev_valid`&`ev_ready`. `ev_valid` falls on the next edge unless it is reloaded in that same cycle.
- Simultaneous transfer and completing byte: the new event loads and `ev_valid` stays 1. This is not an overflow.
- `ev_ready` with `ev_valid`=0 has no effect.
- Back-to-back `byte_valid` on consecutive cycles is supported. This is not required by the UART rate, but the parser must handle it.

## Structure
- `midi_pkg` contains:
  - `ev_type_t` enum, 2 bits.
  - Parser state enum.
  - Status nibble constants: `ST_NOTE_OFF`=8, `ST_NOTE_ON`=9, `ST_POLY_AT`=A, `ST_CC`=B, `ST_PROG`=C, `ST_CH_AT`=D, `ST_BEND`=E.
  - Constants `SYS_SYSEX`=0xF0, `SYS_EOX`=0xF7, `RT_MIN`=0xF8.
- Implemented as a single module with no sub-modules. The top level connects UART `rx_done`→`byte_valid` and `dout`→`byte_in`.

## Test plan
- 0x90,0x3C,0x64 with `ev_ready`=1 → one event {NOTE_ON, ch0, 60, 100}, `ev_valid` high for 1 cycle.
- Running status: 0x91,0x40,0x50,0x40,0x00 → {NOTE_ON, ch1, 64, 80}, then {NOTE_OFF, ch1, 64, 0}.
- Real-time/SysEx mixed in: 0xE0,0xF8,0x00,0xFE,0x40 → {BEND, ch0, 0, 64}. Then 0xF0,0x7E,0x01,0xF7,0x05 → no event; data byte 0x05 is discarded in IDLE.
- 0xC2,0x05,0x06 then 0xB2,0x07,0x7F → no events for program change, then {CC, ch2, 7, 127}.
- `OMNI`=0, `CHANNEL`=3: 0x92,0x3C,0x40 → no event; 0x93,0x3C,0x40 → event on ch3.
- Hold `ev_ready`=0, send two complete note-ons → first event held unchanged, `ev_overflow` pulses once. Assert `reset` mid-message (after 0x90,0x3C) → all outputs 0 immediately; a following 0x3C,0x40 produces no event.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI channel-message parser.
package midi_pkg;

    typedef enum logic [1:0] {
        EV_NOTE_OFF = 2'd0,
        EV_NOTE_ON  = 2'd1,
        EV_CC       = 2'd2,
        EV_BEND     = 2'd3
    } ev_type_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_D1 = 2'd1,
        S_WAIT_D2 = 2'd2,
        S_SYSEX   = 2'd3
    } parse_state_t;

    // Upper nibble of channel status bytes
    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_POLY_AT  = 4'hA;
    localparam logic [3:0] ST_CC       = 4'hB;
    localparam logic [3:0] ST_PROG     = 4'hC;
    localparam logic [3:0] ST_CH_AT    = 4'hD;
    localparam logic [3:0] ST_BEND     = 4'hE;

    localparam logic [7:0] SYS_SYSEX = 8'hF0;
    localparam logic [7:0] SYS_EOX   = 8'hF7;
    localparam logic [7:0] RT_MIN    = 8'hF8;

    // Program change and channel aftertouch carry a single data byte
    function automatic logic one_data_byte(input logic [3:0] nib);
        return (nib == ST_PROG) || (nib == ST_CH_AT);
    endfunction

endpackage

// File: rtl/midi_parser.sv
// MIDI 1.0 channel-message parser: byte stream in, one filtered event out.
// Running status is kept across messages; real-time bytes are transparent;
// SysEx payload is swallowed. The output is a single-entry register.
module midi_parser
    import midi_pkg::*;
#(
    parameter bit         OMNI    = 1'b1,
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [1:0] ev_type,
    output logic [3:0] ev_chan,
    output logic [6:0] ev_d1,
    output logic [6:0] ev_d2,
    output logic       ev_overflow
);

    parse_state_t state, state_next;
    logic [7:0]   status_reg;
    logic [6:0]   d1_reg;

    // Byte classification (only meaningful while byte_valid is high)
    logic is_rt, is_sys, is_chan_st, is_data;
    assign is_rt      = byte_valid && (byte_in >= RT_MIN);
    assign is_sys     = byte_valid && (byte_in[7:4] == 4'hF) && (byte_in < RT_MIN);
    assign is_chan_st = byte_valid && byte_in[7] && (byte_in[7:4] != 4'hF);
    assign is_data    = byte_valid && !byte_in[7];

    logic chan_ok;
    assign chan_ok = OMNI || (status_reg[3:0] == CHANNEL);

    // Decoded event from the byte that completes a message
    logic     ev_gen;
    ev_type_t gen_type;
    logic     out_free;

    // Parser state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state decode; real-time bytes fall through and leave state alone
    always_comb begin
        state_next = state;
        if (is_chan_st) begin
            state_next = S_WAIT_D1;
        end else if (is_sys) begin
            state_next = (byte_in == SYS_SYSEX) ? S_SYSEX : S_IDLE;
        end else if (is_data) begin
            case (state)
                S_WAIT_D1: state_next = one_data_byte(status_reg[7:4]) ? S_WAIT_D1 : S_WAIT_D2;
                S_WAIT_D2: state_next = S_WAIT_D1;
                default:   state_next = state;
            endcase
        end
    end

    // Event decode: only two-byte messages of the four reported kinds emit
    always_comb begin
        ev_gen   = 1'b0;
        gen_type = EV_NOTE_OFF;
        if (is_data && (state == S_WAIT_D2) && chan_ok) begin
            case (status_reg[7:4])
                ST_NOTE_OFF: ev_gen = 1'b1;
                ST_NOTE_ON: begin
                    ev_gen   = 1'b1;
                    gen_type = (byte_in[6:0] != 7'd0) ? EV_NOTE_ON : EV_NOTE_OFF;
                end
                ST_CC: begin
                    ev_gen   = 1'b1;
                    gen_type = EV_CC;
                end
                ST_BEND: begin
                    ev_gen   = 1'b1;
                    gen_type = EV_BEND;
                end
                default: ev_gen = 1'b0;
            endcase
        end
    end

    // Running status and first data byte; system bytes drop running status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_reg <= 8'h00;
            d1_reg     <= 7'd0;
        end else begin
            if (is_chan_st)
                status_reg <= byte_in;
            else if (is_sys)
                status_reg <= 8'h00;
            if (is_data && (state == S_WAIT_D1) && !one_data_byte(status_reg[7:4]))
                d1_reg <= byte_in[6:0];
        end
    end

    // A slot being handed off this cycle counts as free
    assign out_free = !ev_valid || ev_ready;

    // Single-entry output register with drop-on-full overflow pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_valid    <= 1'b0;
            ev_type     <= 2'd0;
            ev_chan     <= 4'd0;
            ev_d1       <= 7'd0;
            ev_d2       <= 7'd0;
            ev_overflow <= 1'b0;
        end else begin
            ev_overflow <= ev_gen && !out_free;
            if (ev_gen && out_free) begin
                ev_valid <= 1'b1;
                ev_type  <= gen_type;
                ev_chan  <= status_reg[3:0];
                ev_d1    <= d1_reg;
                ev_d2    <= byte_in[6:0];
            end else if (ev_valid && ev_ready) begin
                ev_valid <= 1'b0;
            end
        end
    end

    // Real-time bytes are classified only so they can be shown to do nothing
    logic unused_rt;
    assign unused_rt = is_rt;

endmodule
